// File: rtl/adder_share_pkg.sv
// Shared types and constants for the adder-sharing arbiter.
package adder_share_pkg;

  // The adder core is 16 bits wide.
  localparam int WIDTH     = 16;
  localparam int DEF_N_REQ = 3;
  // The tag field is sized for the largest supported requester count (8).
  localparam int OP_ID_W   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               cin;
    logic [OP_ID_W-1:0] id;
  } add_op_t;

endpackage

// File: rtl/adder_share_arbiter_cla.sv
// 16-bit two-level carry-lookahead adder: four 4-bit groups whose carries
// are produced by a group-level lookahead unit.
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] w_p;
  logic [15:0] w_g;
  logic [16:0] w_c;
  logic [3:0]  w_gp;
  logic [3:0]  w_gg;
  logic [4:0]  w_gc;

  assign w_p = a ^ b;
  assign w_g = a & b;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B = 4 * gi;
      // Group generate/propagate feed the second-level lookahead.
      assign w_gg[gi] = w_g[B+3]
                      | (w_p[B+3] & w_g[B+2])
                      | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                      | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
      assign w_gp[gi] = &w_p[B+3:B];
      // Bit carries inside the group, expanded from the group carry-in.
      assign w_c[B]   = w_gc[gi];
      assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[gi]);
      assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B])
                      | (w_p[B+1] & w_p[B] & w_gc[gi]);
      assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1])
                      | (w_p[B+2] & w_p[B+1] & w_g[B])
                      | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[gi]);
    end
  endgenerate

  // Second-level lookahead across the four groups.
  assign w_gc[0] = cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & w_gc[0]);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & w_gc[0]);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & w_gc[0]);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & w_gc[0]);

  assign w_c[16] = w_gc[4];
  assign sum     = w_p ^ w_c[15:0];
  assign cout    = w_c[16];

endmodule

// File: rtl/adder_share_arbiter_rr.sv
// Combinational round-robin arbiter: picks the first requester at or above
// ptr, wrapping modulo N_REQ. Produces a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any_gnt
);

  // Distance of each requester from the pointer, in priority order.
  int w_dist [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_dist
      assign w_dist[gi] = (gi >= int'(ptr)) ? (gi - int'(ptr))
                                            : (gi + N_REQ - int'(ptr));
    end
  endgenerate

  // Pick the valid requester with the smallest distance from the pointer.
  always_comb begin
    int best_dist;
    int best_idx;
    best_dist = N_REQ;
    best_idx  = 0;
    any_gnt   = 1'b0;
    gnt       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (w_dist[i] < best_dist)) begin
        best_dist = w_dist[i];
        best_idx  = i;
        any_gnt   = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      gnt[i] = any_gnt && (best_idx == i);
    end
    gnt_idx = ID_W'(best_idx);
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one 16-bit CLA among N_REQ requesters: round-robin accept in IDLE,
// add from registered operands in EXEC, hold a tagged result in RESP.
module adder_share_arbiter #(
  parameter int N_REQ = adder_share_pkg::DEF_N_REQ,
  parameter int WIDTH = adder_share_pkg::WIDTH,
  parameter int ID_W  = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_cout,
  output logic                   rsp_ovf,
  input  logic                   rsp_ready,
  output logic                   busy
);

  import adder_share_pkg::*;

  state_t           r_state;
  state_t           w_state_next;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  w_rr_ptr_next;
  add_op_t          r_op;

  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_any;
  logic             w_accept;
  logic [N_REQ-1:0] w_req_ready;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_cout;
  logic             r_rsp_ovf;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any_gnt (w_any)
  );

  // The adder only ever sees the registered operands.
  cla16 u_add (
    .a    (r_op.a),
    .b    (r_op.b),
    .cin  (r_op.cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_ovf = (r_op.a[WIDTH-1] == r_op.b[WIDTH-1]) &&
                 (w_sum[WIDTH-1] != r_op.a[WIDTH-1]);

  // Next-state, pointer advance and acceptance; grants only in IDLE.
  always_comb begin
    w_state_next  = r_state;
    w_rr_ptr_next = r_rr_ptr;
    w_req_ready   = '0;
    w_accept      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_req_ready   = w_gnt;
          w_accept      = 1'b1;
          w_state_next  = EXEC;
          w_rr_ptr_next = (int'(w_gnt_idx) == N_REQ - 1) ? '0
                                                         : (w_gnt_idx + ID_W'(1));
        end
      end
      EXEC: w_state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Acceptance is suppressed while reset is held so nothing is granted then.
  assign req_ready = w_req_ready & {N_REQ{~Reset}};

  // State register and round-robin pointer.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_ptr_next;
    end
  end

  // Latch the granted requester's operands and tag at acceptance.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_op <= '0;
    end else if (w_accept) begin
      r_op.a   <= req_a[w_gnt_idx*WIDTH +: WIDTH];
      r_op.b   <= req_b[w_gnt_idx*WIDTH +: WIDTH];
      r_op.cin <= req_cin[w_gnt_idx];
      r_op.id  <= OP_ID_W'(w_gnt_idx);
    end
  end

  // Capture the result at the end of EXEC and hold it until taken.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_ovf   <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= ID_W'(r_op.id);
      r_rsp_sum   <= w_sum;
      r_rsp_cout  <= w_cout;
      r_rsp_ovf   <= w_ovf;
    end else if ((r_state == RESP) && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_ovf   = r_rsp_ovf;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: arithmetic vector table plus hand-written
// round-robin, backpressure, reset and late-request sequences.
module tb_adder_share_arbiter;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int IW = 2;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_cin = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic           rsp_ovf;
  logic           rsp_ready = 1'b0;
  logic           busy;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  adder_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b, input logic cin);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = cin;
  endtask

  // One isolated request from idle through the response handshake.
  task automatic run_vec(input vec_t v);
    set_lane(v.idx, v.a, v.b, v.cin);
    req_valid = 3'b001 << v.idx;
    #1;
    check("vec_grant", req_ready, 32'(3'b001 << v.idx));
    check("vec_idle_busy", busy, 0);
    tick();
    req_valid = '0;
    check("vec_ready_once", req_ready, 0);
    check("vec_exec_busy", busy, 1);
    check("vec_no_early_rsp", rsp_valid, 0);
    tick();
    check("vec_rsp_valid", rsp_valid, 1);
    check("vec_sum", rsp_sum, v.sum);
    check("vec_cout", rsp_cout, v.cout);
    check("vec_ovf", rsp_ovf, v.ovf);
    check("vec_id", rsp_id, v.idx);
    $display("txn req=%0d a=%04h b=%04h cin=%0b -> sum=%04h cout=%0b ovf=%0b id=%0d",
             v.idx, v.a, v.b, v.cin, rsp_sum, rsp_cout, rsp_ovf, rsp_id);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("vec_rsp_drop", rsp_valid, 0);
    check("vec_back_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 16'h1234, 16'h0FED, 1'b1, 16'h2222, 1'b0, 1'b0};
    vecs[1] = '{1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{2, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{2, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[6] = '{0, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[7] = '{1, 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset state, including no grant while reset is held.
    #1 req_valid = 3'b111;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_flags", {rsp_cout, rsp_ovf}, 0);
    req_valid = '0;
    #21 Reset = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Round-robin with all requesters active and the consumer always ready.
    Reset = 1'b1;
    #1 Reset = 1'b0;
    for (int i = 0; i < N; i++) set_lane(i, 16'(16'h1000 * (i + 1)), 16'(16'h0011 * (i + 1)), 1'b0);
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      int e;
      e = g % 3;
      check("rr_grant", req_ready, 32'(3'b001 << e));
      tick();
      check("rr_onehot_exec", req_ready, 0);
      tick();
      check("rr_rsp_valid", rsp_valid, 1);
      check("rr_rsp_id", rsp_id, e);
      check("rr_rsp_sum", rsp_sum, 32'(16'h1011 * (e + 1)));
      $display("txn rr grant=%0d id=%0d sum=%04h", e, rsp_id, rsp_sum);
      tick();
      check("rr_onehot", ($countones(req_ready) <= 1), 1);
    end

    // Backpressure: response held, no new grant despite pending requests.
    rsp_ready = 1'b0;
    check("bp_grant", req_ready, 3'b010);
    tick();
    tick();
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_id", rsp_id, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_sum", rsp_sum, 16'h2022);
      check("bp_hold_id", rsp_id, 1);
      check("bp_no_grant", req_ready, 0);
      check("bp_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_idle", busy, 0);
    check("bp_rsp_drop", rsp_valid, 0);
    check("bp_next_grant", req_ready, 3'b100);
    $display("txn backpressure released, next grant=%0b", req_ready);

    // Reset while in EXEC.
    tick();
    check("rexec_busy", busy, 1);
    Reset = 1'b1;
    #1;
    check("rexec_busy0", busy, 0);
    check("rexec_ready0", req_ready, 0);
    check("rexec_valid0", rsp_valid, 0);
    check("rexec_sum0", rsp_sum, 0);
    #1 Reset = 1'b0;
    #1;
    check("rexec_first_grant", req_ready, 3'b001);
    check("rexec_no_stale", rsp_valid, 0);
    $display("txn reset in EXEC, first grant=%0b", req_ready);

    // Reset while in RESP.
    tick();
    tick();
    check("rresp_valid", rsp_valid, 1);
    check("rresp_sum", rsp_sum, 16'h1011);
    Reset = 1'b1;
    #1;
    check("rresp_valid0", rsp_valid, 0);
    check("rresp_sum0", rsp_sum, 0);
    check("rresp_id0", rsp_id, 0);
    check("rresp_busy0", busy, 0);
    req_valid = '0;
    Reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rresp_no_stale", rsp_valid, 0);
      check("rresp_idle", busy, 0);
    end
    $display("txn reset in RESP, result discarded");

    // Late request on 2 during RESP, short-lived request on 1.
    req_valid = 3'b001;
    #1;
    check("late_first", req_ready, 3'b001);
    tick();
    req_valid = '0;
    tick();
    check("late_resp", rsp_valid, 1);
    req_valid = 3'b100;
    #1;
    check("late_no_grant_resp", req_ready, 0);
    tick();
    req_valid = 3'b110;
    #1;
    check("late_pulse_no_grant", req_ready, 0);
    tick();
    req_valid = 3'b100;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("late_grant2", req_ready, 3'b100);
    tick();
    req_valid = '0;
    tick();
    check("late_rsp_id", rsp_id, 2);
    check("late_rsp_sum", rsp_sum, 16'h3033);
    $display("txn late request id=%0d sum=%04h", rsp_id, rsp_sum);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("late_done", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 16-bit carry-lookahead adder among N_REQ requesters in the LC-3 datapath (PC increment, address generation, ALU ADD).
- Arbitrates round-robin, registers the granted operands, computes the sum, and holds a tagged result until the consumer accepts it.
- Sits between the datapath requesters and the single adder instance.
- One operation is in flight at a time.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- WIDTH, 16, operand and sum width. Fixed at 16 for this use, since the adder core is 16-bit.
- ID_W, 2, width of the requester tag. Must satisfy 2^ID_W >= N_REQ.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operation request.
- req_a  in  N_REQ*WIDTH  per-requester operand A, packed; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  per-requester operand B, packed the same way.
- req_cin  in  N_REQ  per-requester carry-in.
- req_ready  out  N_REQ  one-hot acceptance of the request this cycle.
- rsp_valid  out  1  result is held valid.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_sum  out  WIDTH  A+B+cin, modulo 2^WIDTH.
- rsp_cout  out  1  carry out of the MSB.
- rsp_ovf  out  1  two's-complement overflow: (A[15]==B[15]) && (sum[15]!=A[15]).
- rsp_ready  in  1  consumer accepts the result.
- busy  out  1  state is not IDLE.

Behaviour:
- Clock and reset:
  - One clock, Clk.
  - Reset is asynchronous and active-high, port Reset.
  - Reset forces: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, busy=0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching upward from rr_ptr and wrapping modulo N_REQ.
  - req_ready[grant]=1. This is combinational from req_valid and rr_ptr, with no dependence on rsp_ready.
  - Handshake at the clock edge: operands and cin are latched into op_a/op_b/op_cin, id into op_id, rr_ptr <= (grant+1) mod N_REQ, state -> EXEC.
  - With no req_valid asserted: stay in IDLE, rr_ptr unchanged.
- EXEC:
  - The adder is driven from op_* registers only.
  - At the edge: rsp_sum/rsp_cout/rsp_ovf/rsp_id are registered, rsp_valid <= 1, state -> RESP.
  - req_ready=0.
- RESP:
  - Outputs are held stable while rsp_valid && !rsp_ready.
  - On rsp_ready=1: rsp_valid <= 0, state -> IDLE.
  - req_ready=0. There is no accept in the same cycle as the response handshake.
- Latency and throughput:
  - Acceptance edge T; rsp_valid is high after edge T+1.
  - With rsp_ready tied high, rsp_valid lasts exactly 1 cycle.
  - Minimum spacing between acceptances is 3 cycles.
- Requester rule: a[i], b[i], and cin[i] are held stable while req_valid[i] && !req_ready[i]. Requesters may drop req_valid before they are granted.
- Starvation bound: a continuously asserting requester is granted within N_REQ grants.
- Arithmetic:
  - Sum wraps modulo 2^16.
  - Example: 0xFFFF+0x0001+0 gives sum 0x0000, cout=1, ovf=0.
  - Example: 0x7FFF+0x0001 gives 0x8000, cout=0, ovf=1.
- Asynchronous reset in EXEC or RESP:
  - The in-flight result is discarded and no rsp_valid is issued.
  - The requester is already released and must reissue if needed.
- busy equals (state != IDLE).
- Never more than one bit of req_ready is high.

Decomposition:
- Package adder_share_pkg holds:
  - state enum {IDLE, EXEC, RESP}, 2 bits.
  - localparams WIDTH=16 and the default N_REQ.
  - struct add_op_t {a, b, cin, id}.
- Sub-module rr_arbiter(N_REQ):
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, encoded grant index, any-grant flag.
  - Purely combinational.
- The block instantiates the team's 16-bit carry-lookahead adder as its datapath.

Test Plan:
- Single request: req_valid=3'b001, a=0x1234, b=0x0FED, cin=1.
  - Required: req_ready[0] for 1 cycle; rsp_valid 2 edges later with sum=0x2222, cout=0, ovf=0, id=0.
- Wrap/overflow: 0xFFFF+0x0001, cin=0 -> sum 0x0000, cout=1, ovf=0.
  - 0x7FFF+0x0001 -> sum 0x8000, cout=0, ovf=1.
  - 0x8000+0x8000 -> sum 0x0000, cout=1, ovf=1.
- Round-robin: all three req_valid held high, rsp_ready=1.
  - Grant order 0,1,2,0, spaced 3 cycles apart.
  - rsp_id sequence 0,1,2,0.
  - req_ready is one-hot every cycle.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_* stay stable; req_ready stays 0 despite pending requests.
  - rsp_ready=1 -> IDLE on the next edge, then a grant to the next requester.
- Reset mid-op: assert Reset in EXEC and, separately, in RESP.
  - All outputs go to 0 immediately, without waiting for Clk.
  - After release, the first grant goes to requester 0 (rr_ptr=0) and no stale rsp_valid appears.
- Late request and withdrawal: req_valid[2] rises while in RESP, then req_valid[1] pulses and drops before IDLE.
  - Grant goes to 2 only; requester 1 is never acknowledged.
